add_round_seq: RTL and testbench

Round sequencer for the 1024-bit lane-wise `add` datapath: 16 independent 64-bit lanes, summed only on rounds where `d % 4 == 0`. It accepts a state/key pair over a valid/ready handshake and drives the external `add` instance for `NUM_ROUNDS` rounds. It feeds the result back as the next state and rotates the key one step per round, then presents the final state over an output handshake. It sits between the hash front-end that loads message state and the downstream finaliser.

---
 rtl/add_round_seq.sv | 103 ++++++++++
 tb/tb_add_round_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_seq.sv
// Round sequencer that drives an external lane-wise `add` block: state and key are fed back for NUM_ROUNDS rounds.
// Optional macro ADD_SEQ_SKIP_EN: visit only rounds with rnd % 4 == 0 (four rounds per cycle).
module add_round_seq #(
  parameter int NUM_ROUNDS = 16,
  parameter int KEY_ROT    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [1023:0] state_in,
  input  logic [1023:0] key_in,
  output logic [7:0]    add_d,
  output logic [1023:0] add_in1,
  output logic [1023:0] add_in2,
  input  logic [1023:0] add_out,
  output logic          done_valid,
  input  logic          done_ready,
  output logic [1023:0] state_out,
  output logic          busy
);

`ifdef ADD_SEQ_SKIP_EN
  localparam int unsigned RND_STEP = 4;
`else
  localparam int unsigned RND_STEP = 1;
`endif
  localparam int unsigned ROT_STEP = (RND_STEP * unsigned'(KEY_ROT)) % 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [1023:0] st;
  logic [1023:0] ky;
  logic [7:0]    rnd;
  logic [1023:0] ky_rot;
  logic          last_round;

  // A zero rotation shifts right by the full width, which yields zero, so the OR leaves ky intact.
  assign ky_rot = (ky << ROT_STEP) | (ky >> (1024 - ROT_STEP));

`ifdef ADD_SEQ_SKIP_EN
  assign last_round = ({1'b0, rnd} + 9'd4) >= 9'(NUM_ROUNDS);
`else
  assign last_round = (rnd == 8'(NUM_ROUNDS - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_valid) state_nx = RUN;
      RUN:     if (last_round)  state_nx = DONE;
      DONE:    if (done_ready)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= '0;
      ky  <= '0;
      rnd <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            st  <= state_in;
            ky  <= key_in;
            rnd <= '0;
          end
        end
        RUN: begin
          st  <= add_out;
          ky  <= ky_rot;
          rnd <= rnd + 8'(RND_STEP);
        end
        DONE: begin
          if (done_ready) rnd <= '0;
        end
        default: ;
      endcase
    end
  end

  assign add_d       = rnd;
  assign add_in1     = st;
  assign add_in2     = ky;
  assign state_out   = st;
  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_add_round_seq.sv
// Scoreboard bench for add_round_seq with NUM_ROUNDS=8, KEY_ROT=64 and a behavioural model of the `add` block.
// Expected states are hand-derived: rounds 0 and 4 add, and the key moves four lanes left between them.
module tb_add_round_seq;
  localparam int NUM_ROUNDS = 8;
  localparam int KEY_ROT    = 64;
`ifdef ADD_SEQ_SKIP_EN
  localparam int RND_STEP = 4;
  localparam int EXP_LAT  = 2;
  localparam int MID_RND  = 4;
`else
  localparam int RND_STEP = 1;
  localparam int EXP_LAT  = 8;
  localparam int MID_RND  = 2;
`endif

  logic          clk;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [1023:0] state_in;
  logic [1023:0] key_in;
  logic [7:0]    add_d;
  logic [1023:0] add_in1;
  logic [1023:0] add_in2;
  logic [1023:0] add_out;
  logic          done_valid;
  logic          done_ready;
  logic [1023:0] state_out;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [1023:0] exp_q[$];

  add_round_seq #(.NUM_ROUNDS(NUM_ROUNDS), .KEY_ROT(KEY_ROT)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .state_in(state_in), .key_in(key_in),
    .add_d(add_d), .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
    .done_valid(done_valid), .done_ready(done_ready),
    .state_out(state_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the external add block: lane-wise modulo 2^64 sum on rounds with d % 4 == 0.
  always_comb begin
    add_out = add_in1;
    if (add_d[1:0] == 2'b00) begin
      for (int k = 0; k < 16; k++)
        add_out[64*k +: 64] = add_in1[64*k +: 64] + add_in2[64*k +: 64];
    end
  end

  task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int lane;
    total++;
    if (act !== exp) begin
      bad++;
      lane = 0;
      for (int k = 15; k >= 0; k--)
        if (act[64*k +: 64] !== exp[64*k +: 64]) lane = k;
      $display("[TB] FAIL %s lane %0d: got %h expected %h", name, lane,
               act[64*lane +: 64], exp[64*lane +: 64]);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done_valid && done_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got a result with an empty scoreboard");
      end else begin
        checkOutput("state_out", state_out, exp_q.pop_front());
      end
    end
  end

  task automatic startJob(input logic [1023:0] s, input logic [1023:0] k, input logic [1023:0] e);
    bit ok;
    int cyc;
    state_in    = s;
    key_in      = k;
    start_valid = 1'b1;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 50) begin
      @(negedge clk);
      ok = start_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    start_valid = 1'b0;
    if (ok) exp_q.push_back(e);
    else checkOutput("accept_timeout", 1024'(0), 1024'(1));
  endtask

  task automatic waitDone();
    int lat;
    lat = 0;
    while (!done_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 1024'(lat), 1024'(EXP_LAT));
  endtask

  task automatic applyStimulus(input logic [1023:0] s, input logic [1023:0] k, input logic [1023:0] e);
    startJob(s, k, e);
    waitDone();
  endtask

  logic [1023:0] st_a, key_a, exp_a;
  logic [1023:0] st_b, key_b, exp_b;
  logic [1023:0] st_c, key_c, exp_c;
  logic [1023:0] st_d, key_d, exp_d, rot_d;

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    done_ready  = 1'b1;
    state_in    = '0;
    key_in      = '0;

    st_a = '0; key_a = '0; exp_a = '0;
    st_b = '0; key_b = '0; exp_b = '0;
    st_c = '0; key_c = '0; exp_c = '0;
    st_d = '0; key_d = '0; exp_d = '0; rot_d = '0;
    for (int k = 0; k < 16; k++) begin
      key_a[64*k +: 64] = 64'(k + 1);
      exp_a[64*k +: 64] = 64'((k + 1) + ((k + 12) % 16) + 1);
      st_b[64*k +: 64]  = 64'hFFFF_FFFF_FFFF_FFFF;
      key_b[64*k +: 64] = 64'd1;
      exp_b[64*k +: 64] = 64'd1;
      st_c[64*k +: 64]  = 64'h8000_0000_0000_0000 + 64'(k);
      key_c[64*k +: 64] = 64'h8000_0000_0000_0000;
      exp_c[64*k +: 64] = 64'h8000_0000_0000_0000 + 64'(k);
    end
    key_d[64*15 +: 64] = 64'd5;
    exp_d[64*15 +: 64] = 64'd5;
    exp_d[64*3  +: 64] = 64'd5;
    rot_d[64*((15 + RND_STEP) % 16) +: 64] = 64'd5;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_start_ready", 1024'(start_ready), 1024'(1));
    checkOutput("reset_done_valid", 1024'(done_valid), 1024'(0));
    checkOutput("reset_busy", 1024'(busy), 1024'(0));
    checkOutput("reset_add_d", 1024'(add_d), 1024'(0));
    checkOutput("reset_add_in1", add_in1, '0);
    checkOutput("reset_add_in2", add_in2, '0);
    checkOutput("reset_state_out", state_out, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] two add rounds, lane wrap, high-bit wrap, key rotation");
    applyStimulus(st_a, key_a, exp_a);
    applyStimulus(st_b, key_b, exp_b);
    applyStimulus(st_c, key_c, exp_c);
    applyStimulus(st_d, key_d, exp_d);

    $display("[TB] reset mid-RUN");
    startJob(st_b, key_b, exp_b);
    begin
      int cyc;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (add_d != 8'(MID_RND) && cyc < 20);
      checkOutput("mid_run_add_d", 1024'(add_d), 1024'(MID_RND));
    end
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_start_ready", 1024'(start_ready), 1024'(1));
    checkOutput("mid_rst_done_valid", 1024'(done_valid), 1024'(0));
    checkOutput("mid_rst_busy", 1024'(busy), 1024'(0));
    checkOutput("mid_rst_add_d", 1024'(add_d), 1024'(0));
    checkOutput("mid_rst_add_in1", add_in1, '0);
    checkOutput("mid_rst_add_in2", add_in2, '0);
    checkOutput("mid_rst_state_out", state_out, '0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(st_a, key_a, exp_a);
    @(posedge clk);
    #1;

    $display("[TB] output backpressure then back-to-back start");
    done_ready = 1'b0;
    startJob(st_c, key_c, exp_c);
    state_in    = st_d;
    key_in      = key_d;
    start_valid = 1'b1;
    waitDone();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_done_valid", 1024'(done_valid), 1024'(1));
      checkOutput("bp_start_ready", 1024'(start_ready), 1024'(0));
      checkOutput("bp_state_out", state_out, exp_c);
    end
    @(posedge clk);
    #1;
    done_ready = 1'b1;
    exp_q.push_back(exp_d);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("release_idle_ready", 1024'(start_ready), 1024'(1));
    checkOutput("release_done_valid", 1024'(done_valid), 1024'(0));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_busy", 1024'(busy), 1024'(1));
    checkOutput("b2b_add_d0", 1024'(add_d), 1024'(0));
    checkOutput("b2b_key0", add_in2, key_d);
    @(negedge clk);
    checkOutput("b2b_add_d1", 1024'(add_d), 1024'(RND_STEP));
    checkOutput("b2b_key1", add_in2, rot_d);
    begin
      int cyc;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 100) begin
        @(posedge clk);
        cyc++;
      end
      checkOutput("scoreboard_drained", 1024'(exp_q.size()), 1024'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
